// File: rtl/out_word_serializer.sv
// Captures signed output words on an asynchronous word clock, buffers them in a FIFO
// and shifts each one off-chip MSB first as a framed serial stream (data, bit clock, frame).
module out_word_serializer #(
  parameter int BW    = 6,
  parameter int DEPTH = 8,
  parameter int DIV   = 4
) (
  input  logic                     CLK,
  input  logic                     RES,
  input  logic                     ENABLE,
  input  logic [BW+14:0]           IN,
  input  logic                     IN_CLK,
  output logic                     SER_DATA,
  output logic                     SER_SCLK,
  output logic                     SER_FRAME,
  output logic [$clog2(DEPTH):0]   FIFO_COUNT,
  output logic                     OVERFLOW
);

  localparam int W   = BW + 15;
  localparam int AW  = $clog2(DEPTH);
  localparam int DW  = $clog2(DIV);
  localparam int BCW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP
  } state_t;

  logic          s1, s2, s3;
  logic          word_edge;
  logic          capture;
  logic          full;
  logic          empty;
  logic          pop;
  logic          wr_en;
  logic          drop;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          overflow;

  state_t         state, state_next;
  logic [DW-1:0]  div_cnt, div_next;
  logic [BCW-1:0] bit_cnt, bit_next;
  logic [W-1:0]   sr, sr_next;

  // Two-flop synchroniser on the word clock plus one extra stage for edge detection.
  always_ff @(posedge CLK) begin
    if (RES) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= IN_CLK;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign word_edge = s2 & ~s3;
  assign capture   = word_edge & ENABLE;
  assign full      = (count == (AW+1)'(DEPTH));
  assign empty     = (count == '0);
  // A pop in the same cycle frees a slot, so a full FIFO can still accept the word.
  assign wr_en     = capture & (~full | pop);
  assign drop      = capture & full & ~pop;

  always_ff @(posedge CLK) begin
    if (RES) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= IN;
  end

  always_ff @(posedge CLK) begin
    if (RES) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      sr      <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= div_next;
      bit_cnt <= bit_next;
      sr      <= sr_next;
    end
  end

  // The divider is reused in GAP to time the inter-frame hold.
  always_comb begin
    state_next = state;
    div_next   = div_cnt;
    bit_next   = bit_cnt;
    sr_next    = sr;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!empty && ENABLE) begin
          pop        = 1'b1;
          sr_next    = mem[rd_ptr];
          div_next   = '0;
          bit_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        if (div_cnt == DW'(DIV-1)) begin
          div_next = '0;
          if (bit_cnt == BCW'(W-1)) begin
            state_next = GAP;
          end else begin
            bit_next = bit_cnt + 1'b1;
            sr_next  = {sr[W-2:0], 1'b0};
          end
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end
      GAP: begin
        if (div_cnt == DW'(DIV-1)) begin
          div_next   = '0;
          state_next = IDLE;
        end else begin
          div_next = div_cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign SER_FRAME  = (state == SHIFT);
  assign SER_SCLK   = SER_FRAME & (div_cnt >= DW'(DIV/2));
  assign SER_DATA   = SER_FRAME & sr[W-1];
  assign FIFO_COUNT = count;
  assign OVERFLOW   = overflow;

endmodule

// File: tb/tb_out_word_serializer.sv
// Directed bench for out_word_serializer: a serial receiver model rebuilds each frame and
// the test compares received words, frame timing and FIFO status against hand-computed values.
module tb_out_word_serializer;

  logic        CLK = 1'b0;
  logic        RES;
  logic        ENABLE;
  logic [20:0] IN;
  logic        IN_CLK;
  logic        SER_DATA;
  logic        SER_SCLK;
  logic        SER_FRAME;
  logic [3:0]  FIFO_COUNT;
  logic        OVERFLOW;

  int checks   = 0;
  int failures = 0;

  logic [20:0] rx_words[$];
  int          rx_bits[$];
  int          rx_len[$];
  logic [20:0] rx_sr;
  int          nbits = 0;
  int          flen  = 0;
  int          glen  = 0;
  int          last_gap = 0;
  logic        prev_frame = 1'b0;
  logic        prev_sclk  = 1'b0;

  typedef struct {
    logic [20:0] word;
    logic [20:0] exp_word;
    int          exp_bits;
    int          exp_len;
  } vec_t;

  vec_t vecs[5];

  out_word_serializer #(.BW(6), .DEPTH(8), .DIV(4)) dut (
    .CLK        (CLK),
    .RES        (RES),
    .ENABLE     (ENABLE),
    .IN         (IN),
    .IN_CLK     (IN_CLK),
    .SER_DATA   (SER_DATA),
    .SER_SCLK   (SER_SCLK),
    .SER_FRAME  (SER_FRAME),
    .FIFO_COUNT (FIFO_COUNT),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Receiver model: shifts SER_DATA in on each SCLK rise inside a frame.
  initial begin
    forever begin
      @(negedge CLK);
      if (SER_FRAME) begin
        if (!prev_frame) begin
          last_gap = glen;
          nbits    = 0;
          flen     = 0;
          rx_sr    = '0;
        end
        flen++;
        if (SER_SCLK && !prev_sclk) begin
          rx_sr = {rx_sr[19:0], SER_DATA};
          nbits++;
        end
      end else begin
        if (prev_frame) begin
          rx_words.push_back(rx_sr);
          rx_bits.push_back(nbits);
          rx_len.push_back(flen);
          glen = 0;
        end
        glen++;
      end
      prev_frame = SER_FRAME;
      prev_sclk  = SER_SCLK;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rx_word(input int i);
    if (rx_words.size() > i) return {11'd0, rx_words[i]};
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int rx_nbits(input int i);
    if (rx_bits.size() > i) return rx_bits[i];
    return -1;
  endfunction

  function automatic int rx_flen(input int i);
    if (rx_len.size() > i) return rx_len[i];
    return -1;
  endfunction

  // One word-clock pulse: 3 cycles high, 3 cycles low, IN held throughout.
  task automatic apply_stimulus(input logic [20:0] w);
    @(negedge CLK);
    IN     = w;
    IN_CLK = 1'b1;
    repeat (3) @(negedge CLK);
    IN_CLK = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic clear_rx();
    rx_words.delete();
    rx_bits.delete();
    rx_len.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RES    = 1'b1;
    IN_CLK = 1'b0;
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    @(negedge CLK);
    clear_rx();
  endtask

  task automatic wait_rx(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (rx_words.size() < n && c < budget) begin
      @(negedge CLK);
      c++;
    end
    check_output(name, (rx_words.size() >= n), 32'd1);
  endtask

  task automatic wait_nbits(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (!(SER_FRAME && nbits >= n) && c < budget) begin
      @(negedge CLK);
      c++;
    end
    check_output(name, (SER_FRAME && nbits >= n), 32'd1);
  endtask

  initial begin
    int first_hi;
    logic [3:0] cnt_n2, cnt_n3;
    logic [20:0] conc_words[20];

    vecs[0] = '{word: 21'h000001, exp_word: 21'h000001, exp_bits: 21, exp_len: 84};
    vecs[1] = '{word: 21'h155555, exp_word: 21'h155555, exp_bits: 21, exp_len: 84};
    vecs[2] = '{word: 21'h0F0F0F, exp_word: 21'h0F0F0F, exp_bits: 21, exp_len: 84};
    vecs[3] = '{word: 21'h1FFFFE, exp_word: 21'h1FFFFE, exp_bits: 21, exp_len: 84};
    vecs[4] = '{word: 21'h100001, exp_word: 21'h100001, exp_bits: 21, exp_len: 84};

    RES    = 1'b1;
    ENABLE = 1'b0;
    IN     = '0;
    IN_CLK = 1'b0;
    do_reset();
    check_output("reset SER_DATA",   {31'd0, SER_DATA},   32'd0);
    check_output("reset SER_SCLK",   {31'd0, SER_SCLK},   32'd0);
    check_output("reset SER_FRAME",  {31'd0, SER_FRAME},  32'd0);
    check_output("reset FIFO_COUNT", {28'd0, FIFO_COUNT}, 32'd0);
    check_output("reset OVERFLOW",   {31'd0, OVERFLOW},   32'd0);

    // Single word with latency measurement.
    ENABLE = 1'b1;
    @(negedge CLK);
    IN       = 21'h12345;
    IN_CLK   = 1'b1;
    first_hi = -1;
    cnt_n2   = 4'hF;
    cnt_n3   = 4'hF;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      if (i == 2) cnt_n2 = FIFO_COUNT;
      if (i == 3) begin
        cnt_n3 = FIFO_COUNT;
        IN_CLK = 1'b0;
      end
      if (SER_FRAME && first_hi < 0) first_hi = i;
    end
    check_output("count before write", {28'd0, cnt_n2}, 32'd0);
    check_output("count after write",  {28'd0, cnt_n3}, 32'd1);
    check_output("frame latency",      first_hi,        32'd4);
    wait_rx(1, 200, "single word arrives");
    check_output("single word value", rx_word(0),  32'h12345);
    check_output("single word bits",  rx_nbits(0), 32'd21);
    check_output("single frame len",  rx_flen(0),  32'd84);
    check_output("single count idle", {28'd0, FIFO_COUNT}, 32'd0);

    // Table of isolated words.
    clear_rx();
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(vecs[i].word);
      wait_rx(i + 1, 200, "table word arrives");
      check_output("table word", rx_word(i),  {11'd0, vecs[i].exp_word});
      check_output("table bits", rx_nbits(i), vecs[i].exp_bits);
      check_output("table len",  rx_flen(i),  vecs[i].exp_len);
      repeat (10) @(negedge CLK);
      check_output("table count idle", {28'd0, FIFO_COUNT}, 32'd0);
    end

    // Back-to-back negative extremes.
    clear_rx();
    apply_stimulus(21'h1FFFFF);
    apply_stimulus(21'h100000);
    wait_rx(2, 300, "negative pair arrives");
    check_output("neg word -1",     rx_word(0), 32'h1FFFFF);
    check_output("neg word -2^20",  rx_word(1), 32'h100000);
    check_output("neg gap cycles",  last_gap,   32'd5);
    check_output("neg len second",  rx_flen(1), 32'd84);

    // Overflow while a frame is in flight.
    do_reset();
    ENABLE = 1'b1;
    apply_stimulus(21'h0AAAA);
    for (int v = 1; v <= 10; v++) apply_stimulus(21'(v));
    check_output("ovf count full", {28'd0, FIFO_COUNT}, 32'd8);
    check_output("ovf flag set",   {31'd0, OVERFLOW},   32'd1);
    wait_rx(9, 1200, "ovf frames arrive");
    check_output("ovf first word", rx_word(0), 32'h0AAAA);
    for (int v = 1; v <= 8; v++) check_output("ovf word order", rx_word(v), 32'(v));
    repeat (150) @(negedge CLK);
    check_output("ovf no extra frames", rx_words.size(), 32'd9);
    check_output("ovf flag sticky",     {31'd0, OVERFLOW}, 32'd1);
    do_reset();
    check_output("ovf cleared by reset", {31'd0, OVERFLOW}, 32'd0);

    // ENABLE dropped mid-frame with words buffered.
    ENABLE = 1'b1;
    apply_stimulus(21'h00101);
    apply_stimulus(21'h00202);
    apply_stimulus(21'h00303);
    wait_nbits(10, 200, "enable drop reach bit 10");
    ENABLE = 1'b0;
    apply_stimulus(21'h07777);
    wait_rx(1, 200, "enable drop frame completes");
    repeat (150) @(negedge CLK);
    check_output("enable drop one frame", rx_words.size(), 32'd1);
    check_output("enable drop word",      rx_word(0),       32'h00101);
    check_output("enable drop retained",  {28'd0, FIFO_COUNT}, 32'd2);
    ENABLE = 1'b1;
    wait_rx(3, 400, "enable resume frames");
    check_output("enable resume word 2", rx_word(1), 32'h00202);
    check_output("enable resume word 3", rx_word(2), 32'h00303);
    repeat (150) @(negedge CLK);
    check_output("enable ignored pulse", rx_words.size(), 32'd3);
    check_output("enable count drained", {28'd0, FIFO_COUNT}, 32'd0);

    // Reset in the middle of a frame with one word still buffered.
    do_reset();
    ENABLE = 1'b1;
    apply_stimulus(21'h11111);
    apply_stimulus(21'h22222);
    wait_nbits(5, 200, "reset reach bit 5");
    check_output("reset mid count before", {28'd0, FIFO_COUNT}, 32'd1);
    RES = 1'b1;
    @(negedge CLK);
    check_output("reset mid SER_DATA",   {31'd0, SER_DATA},   32'd0);
    check_output("reset mid SER_SCLK",   {31'd0, SER_SCLK},   32'd0);
    check_output("reset mid SER_FRAME",  {31'd0, SER_FRAME},  32'd0);
    check_output("reset mid FIFO_COUNT", {28'd0, FIFO_COUNT}, 32'd0);
    RES = 1'b0;
    repeat (5) @(negedge CLK);
    clear_rx();
    repeat (150) @(negedge CLK);
    check_output("reset flushed fifo", rx_words.size(), 32'd0);
    apply_stimulus(21'h0ABCD);
    wait_rx(1, 200, "post reset word arrives");
    check_output("post reset word", rx_word(0),  32'h0ABCD);
    check_output("post reset bits", rx_nbits(0), 32'd21);
    check_output("post reset len",  rx_flen(0),  32'd84);

    // Sustained stream: after three quick words, one word per 89 cycles so each
    // write lands on the same cycle as a pop and the pointers wrap twice.
    do_reset();
    ENABLE = 1'b1;
    for (int n = 0; n < 20; n++) conc_words[n] = 21'h0C000 + 21'(n * 21'h01111);
    for (int n = 0; n < 20; n++) begin
      apply_stimulus(conc_words[n]);
      if (n < 2) begin
        // next pulse 6 cycles later
      end else if (n == 2) begin
        repeat (72) @(negedge CLK);
      end else begin
        check_output("stream count steady", {28'd0, FIFO_COUNT}, 32'd2);
        repeat (83) @(negedge CLK);
      end
    end
    wait_rx(20, 600, "stream all arrive");
    for (int n = 0; n < 20; n++) check_output("stream word order", rx_word(n), {11'd0, conc_words[n]});
    check_output("stream no overflow", {31'd0, OVERFLOW},   32'd0);
    check_output("stream count empty", {28'd0, FIFO_COUNT}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
